// File: rtl/axi_lite_demo_regs_if.sv
// Register-side handshake between the AXI-Lite slave and the demo register bank.
// The master side is the AXI-Lite slave front end; the slave side is the register bank.
interface axi_lite_demo_regs_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  i_reg_in_rdy;
  logic                  o_reg_in_ack_stb;
  logic [ADDR_WIDTH-1:0] i_reg_address;
  logic [DATA_WIDTH-1:0] i_reg_in_data;
  logic                  i_reg_out_req;
  logic                  o_reg_out_rdy_stb;
  logic [DATA_WIDTH-1:0] o_reg_out_data;
  logic                  o_reg_invalid_addr;
  logic                  o_irq;

  modport master (
    output i_reg_in_rdy, i_reg_address, i_reg_in_data, i_reg_out_req,
    input  o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_out_data, o_reg_invalid_addr, o_irq
  );

  modport slave (
    input  i_reg_in_rdy, i_reg_address, i_reg_in_data, i_reg_out_req,
    output o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_out_data, o_reg_invalid_addr, o_irq
  );
endinterface

// File: rtl/axi_lite_demo_regs.sv
// Demo register bank behind the AXI-Lite slave: seven registers plus a
// down-counting timer with a sticky interrupt.
//
// state  | meaning
// W_IDLE | waiting for a write request; performs the write on the accepting edge
// W_DONE | write acked, waiting for the slave to drop rdy
// R_IDLE | waiting for a read request
// R_WAIT | counting down read latency; strobe with data when the counter is 0
// R_DONE | strobe given, waiting for the slave to drop req
module axi_lite_demo_regs #(
  parameter int          ADDR_WIDTH   = 16,
  parameter int          DATA_WIDTH   = 32,
  parameter int          READ_LATENCY = 0,
  parameter logic [31:0] VERSION      = 32'h0001_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_lite_demo_regs_if.slave  bus
);
  typedef enum logic {W_IDLE, W_DONE} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DONE} r_state_t;

  localparam logic [5:0] IDX_CONTROL   = 6'd0;
  localparam logic [5:0] IDX_STATUS    = 6'd1;
  localparam logic [5:0] IDX_RELOAD    = 6'd2;
  localparam logic [5:0] IDX_COUNT     = 6'd3;
  localparam logic [5:0] IDX_IRQ_CLEAR = 6'd4;
  localparam logic [5:0] IDX_SCRATCH   = 6'd5;
  localparam logic [5:0] IDX_VERSION   = 6'd6;
  localparam logic [3:0] LATENCY       = 4'(READ_LATENCY);

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                  do_write;
  logic                  ack_q;
  logic                  wr_invalid_q;
  logic                  rd_stb;
  logic                  lat_load;
  logic                  lat_dec;
  logic [3:0]            lat_cnt;
  logic [5:0]            idx;
  logic                  addr_valid;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  timer_en;
  logic                  auto_reload;
  logic                  irq_en;
  logic                  irq_pending;
  logic                  irq_q;
  logic [DATA_WIDTH-1:0] reload;
  logic [DATA_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0] scratch;
  logic                  expire;
  logic                  wr_control;
  logic                  wr_reload;
  logic                  wr_clear;
  logic                  wr_scratch;
  logic                  unused_addr_bits;

  assign idx              = bus.i_reg_address[7:2];
  assign addr_valid       = (idx <= IDX_VERSION);
  assign wdata            = bus.i_reg_in_data;
  assign unused_addr_bits = ^{bus.i_reg_address[1:0], bus.i_reg_address[ADDR_WIDTH-1:8]};

  // Write FSM
  always_comb begin
    w_next   = w_state;
    do_write = 1'b0;
    case (w_state)
      W_IDLE: if (bus.i_reg_in_rdy) begin
        do_write = 1'b1;
        w_next   = W_DONE;
      end
      W_DONE: if (!bus.i_reg_in_rdy) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state      <= W_IDLE;
      ack_q        <= 1'b0;
      wr_invalid_q <= 1'b0;
    end else begin
      w_state      <= w_next;
      ack_q        <= do_write;
      wr_invalid_q <= do_write & ~addr_valid;
    end
  end

  // Read FSM; a pending write takes precedence over a read request
  always_comb begin
    r_next   = r_state;
    lat_load = 1'b0;
    lat_dec  = 1'b0;
    rd_stb   = 1'b0;
    case (r_state)
      R_IDLE: if (bus.i_reg_out_req && !bus.i_reg_in_rdy && w_state == W_IDLE) begin
        r_next   = R_WAIT;
        lat_load = 1'b1;
      end
      R_WAIT: if (lat_cnt == 4'd0) begin
        rd_stb = 1'b1;
        r_next = R_DONE;
      end else begin
        lat_dec = 1'b1;
      end
      R_DONE: if (!bus.i_reg_out_req) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      lat_cnt <= 4'd0;
    end else begin
      r_state <= r_next;
      if (lat_load)     lat_cnt <= LATENCY;
      else if (lat_dec) lat_cnt <= lat_cnt - 4'd1;
    end
  end

  always_comb begin
    rd_data = '0;
    case (idx)
      IDX_CONTROL: rd_data = {{(DATA_WIDTH-3){1'b0}}, irq_en, auto_reload, timer_en};
      IDX_STATUS:  rd_data = {{(DATA_WIDTH-2){1'b0}}, irq_pending, timer_en};
      IDX_RELOAD:  rd_data = reload;
      IDX_COUNT:   rd_data = count;
      IDX_SCRATCH: rd_data = scratch;
      IDX_VERSION: rd_data = VERSION;
      default:     rd_data = '0;
    endcase
  end

  assign wr_control = do_write && idx == IDX_CONTROL;
  assign wr_reload  = do_write && idx == IDX_RELOAD;
  assign wr_clear   = do_write && idx == IDX_IRQ_CLEAR && wdata[0];
  assign wr_scratch = do_write && idx == IDX_SCRATCH;
  assign expire     = timer_en && count == DATA_WIDTH'(1);

  // Software writes take priority over timer updates; expiry beats IRQ clear
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_en    <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      irq_pending <= 1'b0;
      irq_q       <= 1'b0;
      reload      <= '0;
      count       <= '0;
      scratch     <= '0;
    end else begin
      if (wr_control) begin
        timer_en    <= wdata[0];
        auto_reload <= wdata[1];
        irq_en      <= wdata[2];
      end else if (expire && !auto_reload) begin
        timer_en <= 1'b0;
      end

      if (wr_reload) begin
        reload <= wdata;
        count  <= wdata;
      end else if (timer_en) begin
        if (count == '0)  count <= reload;
        else if (expire)  count <= auto_reload ? reload : '0;
        else              count <= count - DATA_WIDTH'(1);
      end

      if (expire)        irq_pending <= 1'b1;
      else if (wr_clear) irq_pending <= 1'b0;

      if (wr_scratch) scratch <= wdata;
      irq_q <= irq_pending & irq_en;
    end
  end

  assign bus.o_reg_in_ack_stb   = ack_q;
  assign bus.o_reg_out_rdy_stb  = rd_stb;
  assign bus.o_reg_out_data     = rd_stb ? rd_data : '0;
  assign bus.o_reg_invalid_addr = ack_q ? wr_invalid_q : (rd_stb & ~addr_valid);
  assign bus.o_irq              = irq_q;
endmodule

// File: tb/tb_axi_lite_demo_regs.sv
// Scoreboard bench for axi_lite_demo_regs: directed register traffic, timer
// interrupt timing, same-cycle conflicts and reset during a read.
module tb_axi_lite_demo_regs;
  localparam int RL = 3;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    bit          inv;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  logic irq_d;
  exp_t sb[$];
  int   rise_q[$];
  int   fall_q[$];

  axi_lite_demo_regs_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  axi_lite_demo_regs #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .READ_LATENCY(RL), .VERSION(32'h0001_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a response
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_reg_in_ack_stb || bus.o_reg_out_rdy_stb) begin
        chk("ack/strobe overlap", 32'(bus.o_reg_in_ack_stb & bus.o_reg_out_rdy_stb), 32'h0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected response: ack=%b stb=%b data=%h, expected no response",
                   bus.o_reg_in_ack_stb, bus.o_reg_out_rdy_stb, bus.o_reg_out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("response kind (1=read)", 32'(bus.o_reg_out_rdy_stb), 32'(e.is_rd));
          if (e.is_rd) chk("read data", bus.o_reg_out_data, e.data);
          chk("invalid flag", 32'(bus.o_reg_invalid_addr), 32'(e.inv));
        end
      end else begin
        chk("data zero outside strobe", bus.o_reg_out_data, 32'h0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      irq_d <= 1'b0;
    end else begin
      if (bus.o_irq && !irq_d) rise_q.push_back(cyc);
      if (!bus.o_irq && irq_d) fall_q.push_back(cyc);
      irq_d <= bus.o_irq;
    end
  end

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input bit inv,
                          output int ack_cyc);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    ack_cyc = 0;
    sb.push_back('{is_rd: 1'b0, data: 32'h0, inv: inv});
    bus.i_reg_address = a;
    bus.i_reg_in_data = d;
    bus.i_reg_in_rdy  = 1'b1;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.o_reg_in_ack_stb) begin
        seen = 1;
        ack_cyc = cyc;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL write ack timeout addr=%h: no ack within %0d cycles", a, n);
    end else begin
      chk("write ack latency", 32'(n), 32'd2);
    end
    @(posedge clk); #1;
    bus.i_reg_in_rdy = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [31:0] d, input bit inv,
                         input int hold);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    sb.push_back('{is_rd: 1'b1, data: d, inv: inv});
    bus.i_reg_address = a;
    bus.i_reg_out_req = 1'b1;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.o_reg_out_rdy_stb) seen = 1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL read strobe timeout addr=%h: no strobe within %0d cycles", a, n);
    end else begin
      chk("read strobe latency", 32'(n), 32'(2 + RL));
    end
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    bus.i_reg_out_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_count(input int which, input int want);
    int n;
    n = 0;
    while (((which == 0) ? rise_q.size() : fall_q.size()) < want && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL irq edge timeout (%s #%0d): not seen within 40 cycles",
               (which == 0) ? "rise" : "fall", want);
    end
  endtask

  initial begin
    int ack_c;
    int ctrl_ack;
    int clr_ack;
    cyc = 0;
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.i_reg_in_rdy  = 1'b0;
    bus.i_reg_out_req = 1'b0;
    bus.i_reg_address = '0;
    bus.i_reg_in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ack",     32'(bus.o_reg_in_ack_stb),   32'h0);
    chk("reset strobe",  32'(bus.o_reg_out_rdy_stb),  32'h0);
    chk("reset data",    bus.o_reg_out_data,          32'h0);
    chk("reset invalid", 32'(bus.o_reg_invalid_addr), 32'h0);
    chk("reset irq",     32'(bus.o_irq),              32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_read(16'h0000, 32'h0, 0, 0);
    do_read(16'h0004, 32'h0, 0, 0);
    do_read(16'h0008, 32'h0, 0, 0);
    do_read(16'h000C, 32'h0, 0, 0);
    do_read(16'h0014, 32'h0, 0, 0);
    do_read(16'h0018, 32'h0001_0000, 0, 10);

    do_write(16'h0014, 32'hDEAD_BEEF, 0, ack_c);
    do_read(16'h0014, 32'hDEAD_BEEF, 0, 0);
    do_read(16'h0114, 32'hDEAD_BEEF, 0, 0);

    do_write(16'h0040, 32'h0000_1234, 1, ack_c);
    do_read(16'h0040, 32'h0, 1, 0);
    do_read(16'h0014, 32'hDEAD_BEEF, 0, 0);
    do_read(16'h0000, 32'h0, 0, 0);

    do_write(16'h000C, 32'h0000_0077, 0, ack_c);
    do_read(16'h000C, 32'h0, 0, 0);
    do_write(16'h0018, 32'h0000_0077, 0, ack_c);
    do_read(16'h0018, 32'h0001_0000, 0, 0);
    do_read(16'h0010, 32'h0, 0, 0);
    do_write(16'h0000, 32'hFFFF_FFFC, 0, ack_c);
    do_read(16'h0000, 32'h4, 0, 0);
    do_write(16'h0000, 32'h0, 0, ack_c);

    do_write(16'h0008, 32'h0000_0055, 0, ack_c);
    do_read(16'h0008, 32'h55, 0, 0);
    do_read(16'h000C, 32'h55, 0, 0);

    // Auto-reload timer with interrupt
    rise_q.delete();
    fall_q.delete();
    do_write(16'h0008, 32'd5, 0, ack_c);
    do_write(16'h0000, 32'h7, 0, ctrl_ack);
    wait_count(0, 1);
    if (rise_q.size() >= 1) chk("irq first rise after enable", 32'(rise_q[0] - ctrl_ack), 32'd6);
    do_write(16'h0010, 32'h1, 0, clr_ack);
    wait_count(1, 1);
    if (fall_q.size() >= 1) chk("irq fall after clear", 32'(fall_q[0] - clr_ack), 32'd1);
    wait_count(0, 2);
    if (rise_q.size() >= 2) chk("irq period", 32'(rise_q[1] - rise_q[0]), 32'd5);
    do_write(16'h0000, 32'h0, 0, ack_c);
    do_write(16'h0010, 32'h1, 0, ack_c);
    do_read(16'h0004, 32'h0, 0, 0);

    // One-shot
    do_write(16'h0008, 32'd3, 0, ack_c);
    do_write(16'h0000, 32'h1, 0, ack_c);
    do_read(16'h000C, 32'h0, 0, 0);
    do_read(16'h0004, 32'h2, 0, 0);
    do_read(16'h0000, 32'h0, 0, 0);
    do_write(16'h0010, 32'h1, 0, ack_c);
    do_read(16'h0004, 32'h0, 0, 0);

    // IRQ_CLEAR lands on the expiry edge (writes are three edges apart)
    do_write(16'h0008, 32'd3, 0, ack_c);
    do_write(16'h0000, 32'h1, 0, ack_c);
    do_write(16'h0010, 32'h1, 0, ack_c);
    do_read(16'h0004, 32'h2, 0, 0);
    do_write(16'h0010, 32'h1, 0, ack_c);
    do_read(16'h0004, 32'h0, 0, 0);

    // Reset while the read is in R_WAIT: no response expected
    bus.i_reg_address = 16'h0014;
    bus.i_reg_out_req = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_reg_out_req = 1'b0;
    @(negedge clk);
    chk("mid-read reset strobe",  32'(bus.o_reg_out_rdy_stb),  32'h0);
    chk("mid-read reset ack",     32'(bus.o_reg_in_ack_stb),   32'h0);
    chk("mid-read reset data",    bus.o_reg_out_data,          32'h0);
    chk("mid-read reset invalid", 32'(bus.o_reg_invalid_addr), 32'h0);
    chk("mid-read reset irq",     32'(bus.o_irq),              32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_read(16'h0014, 32'h0, 0, 0);
    do_read(16'h0000, 32'h0, 0, 0);

    repeat (10) @(posedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
